// File: rtl/wbu.sv
// wbu: write-back unit with one-entry retire buffer, pending-register scoreboard, halt FSM and instret counter
module wbu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd_addr,
  input  logic [WIDTH-1:0] in_rd_data,
  input  logic             in_rd_wen,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             in_ebreak,
  output logic             rf_wen,
  output logic [4:0]       rf_rd_addr,
  output logic [WIDTH-1:0] rf_rd_data,
  output logic             commit_valid,
  input  logic             commit_ready,
  output logic [WIDTH-1:0] commit_pc,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [63:0]      instret,
  output logic             halted
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic buf_valid, b_wen, b_ebreak, capture, retire;
  logic [4:0] b_rd;
  logic [WIDTH-1:0] b_data, b_pc;
  logic [31:0] busy, busy_n, set_mask, clr_mask;
  logic [63:0] instret_q;
  assign rf_rd_addr = b_rd;
  assign rf_rd_data = b_data;
  assign commit_pc  = b_pc;
  assign instret    = instret_q;
  assign rs1_busy   = busy[rs1_addr];
  assign rs2_busy   = busy[rs2_addr];
  // Handshakes and halt FSM next state; reset forces every strobe low
  always_comb begin
    halted       = ~rst & (state == HALT);
    in_ready     = ~rst & (state == RUN) & (~buf_valid | commit_ready);
    commit_valid = ~rst & buf_valid;
    retire       = commit_valid & commit_ready;
    capture      = in_valid & in_ready;
    rf_wen       = retire & b_wen & (b_rd != 5'd0);
    state_n      = (retire & b_ebreak) ? HALT : state;
    set_mask     = (issue_valid && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
    clr_mask     = rf_wen ? (32'd1 << b_rd) : 32'd0;
    busy_n       = ((busy & ~clr_mask) | set_mask) & ~32'd1;
  end
  // State, buffer, scoreboard and retire counter; a set beats a clear on the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      buf_valid <= 1'b0;
      b_rd      <= '0;
      b_data    <= '0;
      b_wen     <= 1'b0;
      b_pc      <= '0;
      b_ebreak  <= 1'b0;
      busy      <= '0;
      instret_q <= '0;
    end else begin
      state     <= state_n;
      buf_valid <= capture | (buf_valid & ~retire);
      busy      <= busy_n;
      instret_q <= instret_q + {63'd0, retire};
      if (capture) begin
        b_rd     <= in_rd_addr;
        b_data   <= in_rd_data;
        b_wen    <= in_rd_wen;
        b_pc     <= in_pc;
        b_ebreak <= in_ebreak;
      end
    end
  end
endmodule

// File: tb/tb_wbu.sv
// tb_wbu: randomized and directed stimulus with a queue-based reference model of the write-back unit
module tb_wbu;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_rd_wen, in_ebreak, rf_wen, commit_valid, commit_ready;
  logic issue_valid, rs1_busy, rs2_busy, halted;
  logic [4:0] in_rd_addr, rf_rd_addr, issue_rd, rs1_addr, rs2_addr;
  logic [31:0] in_rd_data, in_pc, rf_rd_data, commit_pc;
  logic [63:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
    logic [31:0] pc;
    logic        eb;
  } pl_t;

  pl_t sb[$];
  bit m_busy[32];
  bit m_halt;
  logic [63:0] m_cnt;
  int errors = 0;
  int checks = 0;

  wbu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data), .in_rd_wen(in_rd_wen),
    .in_pc(in_pc), .in_ebreak(in_ebreak), .rf_wen(rf_wen), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .instret(instret), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model evaluated just before each rising edge, after inputs have settled
  always @(negedge clk) begin
    bit exp_cv, exp_ir, ret, ewen;
    pl_t p;
    #4;
    if (rst) begin
      chk("in_ready_rst", {63'd0, in_ready}, 64'd0);
      chk("commit_valid_rst", {63'd0, commit_valid}, 64'd0);
      chk("rf_wen_rst", {63'd0, rf_wen}, 64'd0);
      chk("halted_rst", {63'd0, halted}, 64'd0);
      chk("instret_rst", instret, m_cnt);
      sb.delete();
      m_halt = 1'b0;
      m_cnt = '0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      exp_cv = sb.size() != 0;
      exp_ir = !m_halt && (!exp_cv || commit_ready);
      ret = exp_cv && commit_ready;
      ewen = ret && sb[0].wen && sb[0].rd != 5'd0;
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
      chk("commit_valid", {63'd0, commit_valid}, {63'd0, exp_cv});
      if (exp_cv) chk("commit_pc", {32'd0, commit_pc}, {32'd0, sb[0].pc});
      chk("rf_wen", {63'd0, rf_wen}, {63'd0, ewen});
      if (ewen) begin
        chk("rf_rd_addr", {59'd0, rf_rd_addr}, {59'd0, sb[0].rd});
        chk("rf_rd_data", {32'd0, rf_rd_data}, {32'd0, sb[0].data});
      end
      chk("rs1_busy", {63'd0, rs1_busy}, {63'd0, m_busy[rs1_addr]});
      chk("rs2_busy", {63'd0, rs2_busy}, {63'd0, m_busy[rs2_addr]});
      chk("halted", {63'd0, halted}, {63'd0, m_halt});
      chk("instret", instret, m_cnt);
      if (ret) begin
        p = sb.pop_front();
        m_cnt = m_cnt + 64'd1;
        if (p.eb) m_halt = 1'b1;
        if (ewen) m_busy[p.rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
      if (in_valid && exp_ir) sb.push_back('{in_rd_addr, in_rd_data, in_rd_wen, in_pc, in_ebreak});
    end
  end

  task automatic drive(input logic iv, input logic [4:0] rd, input logic [31:0] d, input logic w,
                       input logic [31:0] pc, input logic eb, input logic cr, input logic isv,
                       input logic [4:0] isr, input logic [4:0] r1, input logic r);
    @(negedge clk);
    rst = r; in_valid = iv; in_rd_addr = rd; in_rd_data = d; in_rd_wen = w; in_pc = pc;
    in_ebreak = eb; commit_ready = cr; issue_valid = isv; issue_rd = isr;
    rs1_addr = r1; rs2_addr = isr;
  endtask

  task automatic idle(input logic [4:0] r1, input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1, 0, 0, r1, 0);
  endtask

  initial begin
    m_cnt = '0;
    m_halt = 1'b0;
    rst = 1; in_valid = 0; in_rd_addr = 0; in_rd_data = 0; in_rd_wen = 0; in_pc = 0;
    in_ebreak = 0; commit_ready = 0; issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 5, 5, 0);
    drive(1, 5, 32'hDEADBEEF, 1, 32'h80000000, 0, 1, 0, 0, 5, 0);
    idle(5, 2);
    drive(1, 0, 32'h11111111, 1, 32'h80000004, 0, 1, 1, 9, 9, 0);
    drive(1, 7, 32'h22222222, 0, 32'h80000008, 0, 1, 0, 0, 9, 0);
    idle(9, 2);
    drive(1, 12, 32'hA5A5A5A5, 1, 32'h80000100, 0, 0, 1, 12, 12, 0);
    for (int i = 0; i < 3; i++) drive(1, 13, 32'h5A5A5A5A, 1, 32'h80000104, 0, 0, 0, 0, 12, 0);
    drive(1, 13, 32'h5A5A5A5A, 1, 32'h80000104, 0, 1, 1, 13, 12, 0);
    idle(13, 2);
    drive(1, 3, 32'h33333333, 1, 32'h80000200, 0, 1, 1, 3, 3, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 3, 3, 0);
    idle(3, 2);
    drive(1, 6, 32'h66666666, 1, 32'h80000300, 0, 0, 0, 0, 6, 0);
    @(negedge clk);
    dut.instret_q = '1;
    m_cnt = '1;
    in_valid = 0; commit_ready = 1;
    idle(6, 2);
    drive(1, 4, 32'h44444444, 1, 32'h80000010, 1, 1, 1, 4, 4, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 4, 0);
    for (int i = 0; i < 3; i++) drive(1, 8, 32'h88888888, 1, 32'h80000014, 0, 1, 1, 8, 8, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 8, 1);
    idle(0, 2);
    for (int n = 0; n < 4000; n++) begin
      logic r;
      r = halted ? ($urandom_range(7) == 0) : ($urandom_range(299) == 0);
      drive($urandom_range(3) != 0, 5'($urandom), $urandom, $urandom_range(3) != 0, $urandom,
            $urandom_range(59) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
            5'($urandom), 5'($urandom), r);
    end
    idle(0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
